// File: rtl/sm_pkg.sv
// Shared S-Machine memory-port constants and data-responder state encoding.
// Also used by the interpreter's memory port.
package sm_pkg;

  localparam int unsigned SM_ADDR_W = 8;
  localparam int unsigned SM_DATA_W = 16;

  localparam logic SM_MEM_RD = 1'b0;
  localparam logic SM_MEM_WR = 1'b1;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } sm_resp_state_e;

endpackage

// File: rtl/sm_mem_array.sv
// Single-port DEPTH x DATA_W data store with write-enable and a registered,
// holding read port; out-of-range reads return 0 and out-of-range writes are dropped.
module sm_mem_array
  import sm_pkg::*;
#(
  parameter int unsigned ADDR_W = SM_ADDR_W,
  parameter int unsigned DATA_W = SM_DATA_W,
  parameter int unsigned DEPTH  = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;
  logic              in_range;
  logic [IDX_W-1:0]  idx;

  assign in_range = 32'(addr_i) < DEPTH;
  assign idx      = IDX_W'(addr_i);

  // Storage is deliberately left unreset.
  always_ff @(posedge clk) begin
    if (we_i && in_range) begin
      mem_q[idx] <= wdata_i;
    end
  end

  // Read register only moves on a read, so it holds across writes and idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= in_range ? mem_q[idx] : '0;
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/sm_data_mem_responder.sv
// S-Machine data-bus responder: latency-controlled LD/ST service with a one-deep
// pending slot. Define SM_MEM_WRITE_PROTECT_EN to block writes below WP_LIMIT.
module sm_data_mem_responder
  import sm_pkg::*;
#(
  parameter int unsigned ADDR_W    = SM_ADDR_W,
  parameter int unsigned DATA_W    = SM_DATA_W,
  parameter int unsigned DEPTH     = 256,
  parameter int unsigned READ_LAT  = 2,
  parameter int unsigned WRITE_LAT = 1,
  parameter int unsigned WP_LIMIT  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              read_write_memory,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_out_memory,
  output logic [DATA_W-1:0] data_in_memory,
  output logic              ack,
  output logic              busy,
  output logic              overflow,
  output logic              wp_fault
);

  localparam int unsigned MAX_LAT = (READ_LAT > WRITE_LAT) ? READ_LAT : WRITE_LAT;
  localparam int unsigned CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;
`ifdef SM_MEM_WRITE_PROTECT_EN
  localparam logic WP_EN = 1'b1;
`else
  localparam logic WP_EN = 1'b0;
`endif

  sm_resp_state_e    state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              act_rw_q, act_rw_d;
  logic [ADDR_W-1:0] act_addr_q, act_addr_d;
  logic [DATA_W-1:0] act_data_q, act_data_d;
  logic              pend_vld_q, pend_vld_d;
  logic              pend_rw_q, pend_rw_d;
  logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
  logic [DATA_W-1:0] pend_data_q, pend_data_d;
  logic              ack_q, ack_d;
  logic              wp_q, wp_d;
  logic              ovf_q, ovf_d;
  logic              done_c;
  logic              blocked_c;
  logic              mem_we_c;
  logic              mem_re_c;

  function automatic logic [CNT_W-1:0] lat_load(input logic rw);
    return (rw == SM_MEM_WR) ? CNT_W'(WRITE_LAT - 1) : CNT_W'(READ_LAT - 1);
  endfunction

  // Completion cycle: the active access retires at the end of this cycle.
  assign done_c    = (state_q == ST_ACTIVE) && (cnt_q == '0);
  assign blocked_c = WP_EN && (act_rw_q == SM_MEM_WR) && (32'(act_addr_q) < WP_LIMIT);
  assign mem_we_c  = done_c && (act_rw_q == SM_MEM_WR) && !blocked_c;
  assign mem_re_c  = done_c && (act_rw_q == SM_MEM_RD);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      act_rw_q    <= SM_MEM_RD;
      act_addr_q  <= '0;
      act_data_q  <= '0;
      pend_vld_q  <= 1'b0;
      pend_rw_q   <= SM_MEM_RD;
      pend_addr_q <= '0;
      pend_data_q <= '0;
      ack_q       <= 1'b0;
      wp_q        <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      act_rw_q    <= act_rw_d;
      act_addr_q  <= act_addr_d;
      act_data_q  <= act_data_d;
      pend_vld_q  <= pend_vld_d;
      pend_rw_q   <= pend_rw_d;
      pend_addr_q <= pend_addr_d;
      pend_data_q <= pend_data_d;
      ack_q       <= ack_d;
      wp_q        <= wp_d;
      ovf_q       <= ovf_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    act_rw_d    = act_rw_q;
    act_addr_d  = act_addr_q;
    act_data_d  = act_data_q;
    pend_vld_d  = pend_vld_q;
    pend_rw_d   = pend_rw_q;
    pend_addr_d = pend_addr_q;
    pend_data_d = pend_data_q;
    ovf_d       = ovf_q;

    case (state_q)
      ST_IDLE: begin
        if (req) begin
          state_d    = ST_ACTIVE;
          act_rw_d   = read_write_memory;
          act_addr_d = addr;
          act_data_d = data_out_memory;
          cnt_d      = lat_load(read_write_memory);
        end
      end
      ST_ACTIVE: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
          if (req) begin
            if (!pend_vld_q) begin
              pend_vld_d  = 1'b1;
              pend_rw_d   = read_write_memory;
              pend_addr_d = addr;
              pend_data_d = data_out_memory;
            end else begin
              ovf_d = 1'b1;
            end
          end
        end else if (pend_vld_q) begin
          // Promote the pending request, then refill the slot from req.
          act_rw_d   = pend_rw_q;
          act_addr_d = pend_addr_q;
          act_data_d = pend_data_q;
          cnt_d      = lat_load(pend_rw_q);
          pend_vld_d = req;
          if (req) begin
            pend_rw_d   = read_write_memory;
            pend_addr_d = addr;
            pend_data_d = data_out_memory;
          end
        end else if (req) begin
          act_rw_d   = read_write_memory;
          act_addr_d = addr;
          act_data_d = data_out_memory;
          cnt_d      = lat_load(read_write_memory);
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    ack_d = (state_d == ST_ACTIVE) && (cnt_d == '0);
    wp_d  = ack_d && WP_EN && (act_rw_d == SM_MEM_WR) && (32'(act_addr_d) < WP_LIMIT);
  end

  sm_mem_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_array (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_i    (mem_we_c),
    .re_i    (mem_re_c),
    .addr_i  (act_addr_q),
    .wdata_i (act_data_q),
    .rdata_o (data_in_memory)
  );

  assign ack      = ack_q;
  assign wp_fault = wp_q;
  assign overflow = ovf_q;
  assign busy     = (state_q == ST_ACTIVE) || pend_vld_q;

endmodule

// File: tb/tb_sm_data_mem_responder.sv
// Bench for sm_data_mem_responder: directed literal checks plus randomized traffic
// compared every cycle against a timing-arithmetic model of the request stream.
module tb_sm_data_mem_responder;
  import sm_pkg::*;

  localparam int unsigned ADDR_W    = 8;
  localparam int unsigned DATA_W    = 16;
  localparam int unsigned DEPTH     = 240;
  localparam int unsigned READ_LAT  = 2;
  localparam int unsigned WRITE_LAT = 1;
  localparam int unsigned WP_LIMIT  = 16;
`ifdef SM_MEM_WRITE_PROTECT_EN
  localparam bit WP_ON = 1'b1;
`else
  localparam bit WP_ON = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              req = 1'b0;
  logic              rw = 1'b0;
  logic [ADDR_W-1:0] addr = '0;
  logic [DATA_W-1:0] wdata = '0;
  logic [DATA_W-1:0] data_in_memory;
  logic              ack, busy, overflow, wp_fault;

  always #5 clk = ~clk;

  sm_data_mem_responder #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH),
    .READ_LAT(READ_LAT), .WRITE_LAT(WRITE_LAT), .WP_LIMIT(WP_LIMIT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .read_write_memory(rw), .addr(addr),
    .data_out_memory(wdata), .data_in_memory(data_in_memory), .ack(ack),
    .busy(busy), .overflow(overflow), .wp_fault(wp_fault)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Each accepted request: a = accept edge, s = start edge, c = retire edge.
  // Ack is visible in the cycle after edge c-1; data/commit happen at edge c.
  typedef struct {
    logic              rw;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    int                a;
    int                s;
    int                c;
  } mreq_t;

  mreq_t             q[$];
  mreq_t             m_r, m_nr;
  logic [DATA_W-1:0] mem_m [256];
  bit                known_m [256];
  int                edge_n = 0;
  bit                exp_ack = 0, exp_busy = 0, exp_ovf = 0, exp_wp = 0;
  logic [DATA_W-1:0] exp_data = '0;
  bit                exp_data_known = 1;

  function automatic bit blocked(input logic w, input logic [ADDR_W-1:0] a);
    return WP_ON && (w == SM_MEM_WR) && (int'(a) < int'(WP_LIMIT));
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      exp_ack = 0; exp_busy = 0; exp_ovf = 0; exp_wp = 0;
      exp_data = '0; exp_data_known = 1;
    end else begin
      edge_n++;
      if (q.size() > 0 && q[0].c == edge_n) begin
        m_r = q.pop_front();
        if (m_r.rw == SM_MEM_WR) begin
          if (int'(m_r.addr) < int'(DEPTH) && !blocked(m_r.rw, m_r.addr)) begin
            mem_m[m_r.addr]   = m_r.data;
            known_m[m_r.addr] = 1;
          end
        end else if (int'(m_r.addr) < int'(DEPTH)) begin
          exp_data       = mem_m[m_r.addr];
          exp_data_known = known_m[m_r.addr];
        end else begin
          exp_data       = '0;
          exp_data_known = 1;
        end
      end
      if (req) begin
        if (q.size() > 0 && q[q.size()-1].s > edge_n) begin
          exp_ovf = 1;
        end else begin
          m_nr.rw = rw; m_nr.addr = addr; m_nr.data = wdata; m_nr.a = edge_n;
          m_nr.s = edge_n;
          if (q.size() > 0 && q[q.size()-1].c > m_nr.s) m_nr.s = q[q.size()-1].c;
          m_nr.c = m_nr.s + ((rw == SM_MEM_WR) ? int'(WRITE_LAT) : int'(READ_LAT));
          q.push_back(m_nr);
        end
      end
      exp_ack  = (q.size() > 0) && (q[0].c == edge_n + 1);
      exp_wp   = exp_ack && blocked(q[0].rw, q[0].addr);
      exp_busy = (q.size() > 0);
    end
  end

  int ack_seen = 0;

  always @(negedge clk) begin
    if (ack) ack_seen++;
    check("ack", 32'(ack), 32'(exp_ack));
    check("busy", 32'(busy), 32'(exp_busy));
    check("overflow", 32'(overflow), 32'(exp_ovf));
    check("wp_fault", 32'(wp_fault), 32'(exp_wp));
    if (exp_data_known) check("data_in_memory", 32'(data_in_memory), 32'(exp_data));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit r, input bit w, input logic [ADDR_W-1:0] a,
                       input logic [DATA_W-1:0] d);
    req = r; rw = w; addr = a; wdata = d;
  endtask

  // Leaves time just after the edge that sampled the request.
  task automatic issue(input bit w, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    tick();
    drive(1'b1, w, a, d);
    tick();
    drive(1'b0, 1'b0, '0, '0);
  endtask

  task automatic read_back(input string name, input logic [ADDR_W-1:0] a,
                           input logic [DATA_W-1:0] exp);
    issue(SM_MEM_RD, a, '0);
    repeat (3) @(negedge clk);
    #1 check(name, 32'(data_in_memory), 32'(exp));
  endtask

  int ack_base;
  logic [ADDR_W-1:0] ra;

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_data", 32'(data_in_memory), 32'd0);
    tick();
    rst_n = 1'b1;

    issue(SM_MEM_WR, 8'h01, 16'h0101); repeat (3) tick();
    issue(SM_MEM_WR, 8'h30, 16'h1111); repeat (3) tick();

    // Write then read with default latencies.
    issue(SM_MEM_WR, 8'h20, 16'hBEEF);
    @(negedge clk); #1;
    check("wr_ack_lat1", 32'(ack), 32'd1);
    check("wr_busy", 32'(busy), 32'd1);
    @(negedge clk); #1;
    check("wr_ack_pulse", 32'(ack), 32'd0);
    check("wr_busy_drop", 32'(busy), 32'd0);
    issue(SM_MEM_RD, 8'h20, '0);
    @(negedge clk); #1 check("rd_ack_not_yet", 32'(ack), 32'd0);
    @(negedge clk); #1 check("rd_ack_lat2", 32'(ack), 32'd1);
    @(negedge clk); #1;
    check("rd_data_beef", 32'(data_in_memory), 32'h0000BEEF);
    check("rd_busy_drop", 32'(busy), 32'd0);

    // Back-to-back read then write: second is held pending.
    tick(); drive(1'b1, SM_MEM_RD, 8'h01, '0);
    tick(); drive(1'b1, SM_MEM_WR, 8'h02, 16'h5555);
    tick(); drive(1'b0, 1'b0, '0, '0);
    @(negedge clk); #1;
    check("b2b_ack1", 32'(ack), 32'd1);
    check("b2b_busy1", 32'(busy), 32'd1);
    @(negedge clk); #1;
    check("b2b_ack2", 32'(ack), 32'd1);
    check("b2b_busy2", 32'(busy), 32'd1);
    check("b2b_rd_data", 32'(data_in_memory), 32'h00000101);
    @(negedge clk); #1;
    check("b2b_idle", 32'(busy), 32'd0);
    check("b2b_no_ovf", 32'(overflow), 32'd0);
    read_back("b2b_wr_data", 8'h02, 16'h5555);

    // Four consecutive reads: third lands on a completion cycle, fourth is dropped.
    repeat (2) tick();
    ack_base = ack_seen;
    drive(1'b1, SM_MEM_RD, 8'h20, '0); tick();
    drive(1'b1, SM_MEM_RD, 8'h01, '0); tick();
    drive(1'b1, SM_MEM_RD, 8'h02, '0); tick();
    drive(1'b1, SM_MEM_RD, 8'h30, '0); tick();
    drive(1'b0, 1'b0, '0, '0);
    repeat (10) tick();
    check("ovf_ack_count", 32'(ack_seen - ack_base), 32'd3);
    check("ovf_sticky", 32'(overflow), 32'd1);
    check("ovf_last_data", 32'(data_in_memory), 32'h00005555);

    // Reset during a write abandons it and clears sticky state.
    issue(SM_MEM_WR, 8'h30, 16'h1234);
    rst_n = 1'b0;
    @(negedge clk); #1;
    check("midrst_ack", 32'(ack), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_ovf", 32'(overflow), 32'd0);
    tick(); tick();
    rst_n = 1'b1;
    read_back("midrst_old_data", 8'h30, 16'h1111);

    // Out-of-range write ignored, read returns 0.
    issue(SM_MEM_WR, 8'hF5, 16'h7777);
    @(negedge clk); #1 check("oor_wr_ack", 32'(ack), 32'd1);
    read_back("oor_rd_zero", 8'hF5, 16'h0000);

    issue(SM_MEM_WR, 8'h05, 16'hAAAA);
    @(negedge clk); #1;
    check("wp_ack", 32'(ack), 32'd1);
    check("wp_fault_pulse", 32'(wp_fault), 32'(WP_ON));
    @(negedge clk); #1 check("wp_fault_clear", 32'(wp_fault), 32'd0);
    issue(SM_MEM_RD, 8'h05, '0);
    repeat (3) @(negedge clk);
    #1 check("wp_commit_05", 32'(data_in_memory == 16'hAAAA), 32'(!WP_ON));
    issue(SM_MEM_WR, 8'h10, 16'h0F0F);
    @(negedge clk); #1 check("wp_limit_fault", 32'(wp_fault), 32'd0);
    read_back("wp_limit_commit", 8'h10, 16'h0F0F);

    // Randomized traffic with occasional mid-run reset.
    for (int i = 0; i < 4000; i++) begin
      tick();
      if ($urandom_range(0, 499) == 0) begin
        drive(1'b0, 1'b0, '0, '0);
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
      end else if ($urandom_range(0, 99) < 55) begin
        ra = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(200, 255))
                                         : 8'($urandom_range(0, 31));
        drive(1'b1, 1'($urandom_range(0, 1)), ra, 16'($urandom));
      end else begin
        drive(1'b0, 1'b0, '0, '0);
      end
    end
    drive(1'b0, 1'b0, '0, '0);
    repeat (10) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sm_data_mem_responder.md
Name: sm_data_mem_responder

Overview:
- Memory-side responder for the S-Machine CPU data bus. Services LD (read) and ST (write) requests from the instruction interpreter: address, read/write select and write data in; read data plus completion ack out.
- Holds the 256x16 data store, applies a configurable access latency, and buffers one request that arrives while busy.
- Sits between the interpreter's memory port and the top-level CPU wrapper.

Parameters:
- ADDR_W, 8: address width.
- DATA_W, 16: data word width.
- DEPTH, 256: number of words implemented; must be ≤ 2^ADDR_W.
- READ_LAT, 2: cycles from request accept to ack for reads; must be ≥ 1.
- WRITE_LAT, 1: cycles from request accept to ack for writes; must be ≥ 1.
- WP_LIMIT, 16: addresses below this value are write-protected. Used only when SM_MEM_WRITE_PROTECT_EN is defined.

Ports:
- clk, input, 1: single clock; all state is updated on the rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- req, input, 1: request strobe, sampled at each rising edge.
- read_write_memory, input, 1: 0 = read (LD), 1 = write (ST).
- addr, input, ADDR_W: word address.
- data_out_memory, input, DATA_W: write data from the interpreter.
- data_in_memory, output, DATA_W: read data to the interpreter.
- ack, output, 1: one-cycle completion pulse.
- busy, output, 1: high while an access is in flight or a request is pending.
- overflow, output, 1: sticky flag; a request was dropped.
- wp_fault, output, 1: one-cycle pulse coincident with ack when a write is blocked.

Behaviour:
- Reset: asynchronous and active-low. While rst_n is low:
  - data_in_memory, ack, busy, overflow and wp_fault are all 0.
  - The FSM is in IDLE, the pending slot is empty, and the latency counter is 0.
  - The storage array is not reset.
- Reset mid-operation: the in-flight access is abandoned. A write in flight is not committed, and the pending request is discarded.
- FSM states and transitions:
  - IDLE → ACTIVE: on req high. Latch read_write_memory, addr and data_out_memory. Load the counter with LAT−1, where LAT is READ_LAT or WRITE_LAT for the latched operation.
  - ACTIVE: the counter decrements each cycle. When the counter is 0, the completion cycle occurs:
    - ack pulses high for exactly one cycle.
    - A write commits to the array at this edge.
    - For a read, the array word is registered into data_in_memory at this edge.
  - ACTIVE → IDLE: after completion, if the pending slot is empty.
  - ACTIVE → ACTIVE: after completion, if the pending slot is full. The pending request is moved into the active registers with a fresh counter load, and the slot is cleared.
- Latency: a request sampled at edge k produces ack high in the cycle after edge k+LAT−1 (that is, ack is visible for cycle k+LAT). With LAT=1, ack follows in the very next cycle.
- data_in_memory: updates only on a read completion. It holds its value across writes and idle cycles.
- Pending slot and overflow:
  - req in ACTIVE with the slot empty: the request is captured into the slot.
  - req in ACTIVE with the slot full: the request is dropped and overflow sets. overflow stays set until reset.
  - req in the completion cycle: the old pending request is promoted first, then the new request is captured into the freed slot. No drop occurs.
- Ordering: requests complete strictly in acceptance order. A read after a write to the same address returns the newly written data.
- busy = (state == ACTIVE) OR pending slot full. busy is combinational from registered state.
- Out-of-range addresses (addr ≥ DEPTH): reads return 0 and writes are ignored. ack still pulses normally.
- Arithmetic: the counter is wide enough for max(READ_LAT, WRITE_LAT). No wrap-around is possible by construction.

Optional Feature:
- Macro: SM_MEM_WRITE_PROTECT_EN.
- Defined: a write with addr < WP_LIMIT is not committed. ack still pulses, and wp_fault pulses in the same cycle as that ack. Reads of protected addresses are unaffected.
- Undefined: all in-range writes commit. wp_fault is tied to 0 and WP_LIMIT is ignored.

Decomposition:
- Shared package sm_pkg:
  - Constants SM_ADDR_W = 8 and SM_DATA_W = 16.
  - Read/write encodings SM_MEM_RD = 1'b0 and SM_MEM_WR = 1'b1.
  - Responder state encoding: ST_IDLE, ST_ACTIVE.
  - These constants are shared with the interpreter's memory port.
- One sub-module, sm_mem_array: synchronous single-port DEPTH×DATA_W storage with a write-enable and a registered read. The responder owns the FSM, the pending slot and the flags.

Test Plan:
- Reset, then write 0xBEEF to addr 0x20; later read 0x20 (defaults) → write ack 1 cycle after accept; read ack 2 cycles after accept; data_in_memory = 0xBEEF; busy drops the cycle after ack.
- Assert rst_n low mid-write of 0x1234 to 0x30, release, read 0x30 → returns the prior contents, not 0x1234; ack, busy and overflow are 0 during reset.
- Back-to-back: read 0x01, then req next cycle writing 0x5555 to 0x02 → captured as pending; two acks in order; no overflow; busy stays high continuously until the second ack.
- Three reqs on consecutive cycles with READ_LAT=4 → third request dropped; overflow = 1 and stays 1; only two acks.
- req in the completion cycle of an earlier read → no drop; the pending request promotes; the new request is served after it.
- With SM_MEM_WRITE_PROTECT_EN and WP_LIMIT=16: write 0xAAAA to 0x05 → ack and wp_fault pulse together; a subsequent read of 0x05 returns the old value. A write to 0x10 commits with wp_fault = 0.
